pb_press_classifier: RTL and testbench

Debounces the raw active-low pushbutton (`ui_in[2]`) and classifies each user gesture as a short, long or double press. Emits a one-cycle `press_valid` strobe with a 2-bit `press_type`. Sits directly upstream of the `tt_um_csit_luks` core logic, which consumes `press_type` as its `pb_press_type` input. Time thresholds are in clock cycles, so the bench can shrink them.

---
 rtl/csit_pkg.sv | 23 ++
 rtl/pb_debounce.sv | 54 +++++
 rtl/pb_press_classifier.sv | 117 +++++++++++
 tb/tb_pb_press_classifier.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/csit_pkg.sv
// Shared types for the pushbutton front end and the core that consumes its classification.
package csit_pkg;

  typedef enum logic [1:0] {
    PT_NONE   = 2'b00,
    PT_SHORT  = 2'b01,
    PT_LONG   = 2'b10,
    PT_DOUBLE = 2'b11
  } press_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_LONG_HELD,
    ST_WAIT2,
    ST_PRESS2
  } pb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Two-flop synchronizer and debounce counter for an active-low button; level moves 2+DB_CYCLES clocks after a stable raw edge.
// press_ev/release_ev are single-cycle flags asserted in the cycle before pb_level changes, so consumers step on the same edge.
module pb_debounce
  import csit_pkg::*;
#(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  output logic pb_level,
  output logic press_ev,
  output logic release_ev
);

  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [DW-1:0] r_cnt;
  logic          w_differ;
  logic          w_settle;

  assign w_differ = (r_sync2 != r_level);
  assign w_settle = w_differ && (r_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pb_n;
      r_sync2 <= r_sync1;
      // Any bounce back to the current level restarts the window.
      if (!w_differ || w_settle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_settle) begin
        r_level <= r_sync2;
      end
    end
  end

  assign pb_level   = r_level;
  assign press_ev   = w_settle && !r_sync2;
  assign release_ev = w_settle && r_sync2;

endmodule

// File: rtl/pb_press_classifier.sv
// Debounces the pushbutton and classifies each gesture as SHORT, LONG or DOUBLE with a one-cycle strobe.
// All outputs registered; no backpressure, the consumer must take press_valid when it fires.
module pb_press_classifier
  import csit_pkg::*;
#(
  parameter int DB_CYCLES   = 100000,
  parameter int LONG_CYCLES = 8000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_n,
  output logic       pb_level,
  output logic       press_valid,
  output logic [1:0] press_type
);

  localparam int TW = $clog2(max_int(LONG_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  logic        w_press_ev;
  logic        w_release_ev;
  pb_state_t   r_state;
  pb_state_t   w_state_nxt;
  logic [TW-1:0] r_timer;
  logic        w_emit;
  press_type_t w_emit_type;
  logic        r_press_valid;
  press_type_t r_press_type;

  pb_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .pb_n       (pb_n),
    .pb_level   (pb_level),
    .press_ev   (w_press_ev),
    .release_ev (w_release_ev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_type = PT_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_press_ev) w_state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_release_ev) begin
          w_state_nxt = ST_WAIT2;
        end else if (r_timer == LONG_LAST) begin
          w_state_nxt = ST_LONG_HELD;
          w_emit      = 1'b1;
          w_emit_type = PT_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (w_release_ev) w_state_nxt = ST_IDLE;
      end
      ST_WAIT2: begin
        // A second press landing on the expiry cycle still counts as a double.
        if (w_press_ev) begin
          w_state_nxt = ST_PRESS2;
        end else if (r_timer == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_emit      = 1'b1;
          w_emit_type = PT_SHORT;
        end
      end
      ST_PRESS2: begin
        if (w_release_ev) begin
          w_state_nxt = ST_IDLE;
          w_emit      = 1'b1;
          w_emit_type = PT_DOUBLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_valid <= 1'b0;
      r_press_type  <= PT_NONE;
    end else begin
      r_press_valid <= w_emit;
      if (w_emit) begin
        r_press_type <= w_emit_type;
      end
    end
  end

  assign press_valid = r_press_valid;
  assign press_type  = r_press_type;

endmodule

// File: tb/tb_pb_press_classifier.sv
// Scoreboard bench: stimulus pushes expected (type, cycle) strobes, a negedge monitor pops and compares.
module tb_pb_press_classifier;

  logic       clk;
  logic       rst;
  logic       pb_n;
  logic       pb_level;
  logic       press_valid;
  logic [1:0] press_type;

  typedef struct {
    int ty;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc;
  int   checks;
  int   errors;
  int   n;

  pb_press_classifier #(
    .DB_CYCLES   (4),
    .LONG_CYCLES (40),
    .GAP_CYCLES  (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_n        (pb_n),
    .pb_level    (pb_level),
    .press_valid (press_valid),
    .press_type  (press_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int ty, input int at);
    exp_t x;
    x.ty  = ty;
    x.cyc = at;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst && press_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe type=%0d cyc=%0d expected=no strobe", press_type, cyc);
      end else begin
        e = q.pop_front();
        if (int'(press_type) != e.ty || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe actual type=%0d cyc=%0d expected type=%0d cyc=%0d",
                   press_type, cyc, e.ty, e.cyc);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pb_n   = 1'b1;
    run(3);
    rst = 1'b0;
    check("reset_level", int'(pb_level), 1);
    check("reset_valid", int'(press_valid), 0);
    check("reset_type", int'(press_type), 0);

    run(50);
    check("idle_level", int'(pb_level), 1);
    check("idle_type", int'(press_type), 0);

    // Glitch shorter than the debounce window
    pb_n = 1'b0;
    run(3);
    pb_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(1);
      check("glitch_level", int'(pb_level), 1);
    end
    run(20);

    // Short press: level falls at N+6, rises at N+21, SHORT at N+21+20
    n = cyc;
    push(1, n + 41);
    pb_n = 1'b0;
    run(5);
    check("short_level_before_fall", int'(pb_level), 1);
    run(1);
    check("short_level_fall", int'(pb_level), 0);
    run(9);
    pb_n = 1'b1;
    run(5);
    check("short_level_before_rise", int'(pb_level), 0);
    run(1);
    check("short_level_rise", int'(pb_level), 1);
    run(60);
    check("short_drain", q.size(), 0);

    // Long press: level falls at N+6, LONG at N+46, release emits nothing
    n = cyc;
    push(2, n + 46);
    pb_n = 1'b0;
    run(60);
    pb_n = 1'b1;
    run(60);
    check("long_drain", q.size(), 0);
    check("long_type_held", int'(press_type), 2);

    // Double press: second release_ev seen before edge N+36
    n = cyc;
    push(3, n + 36);
    pb_n = 1'b0;
    run(10);
    pb_n = 1'b1;
    run(10);
    pb_n = 1'b0;
    run(10);
    pb_n = 1'b1;
    run(60);
    check("double_drain", q.size(), 0);
    check("double_type_held", int'(press_type), 3);

    // Reset 5 cycles after release discards the pending SHORT
    pb_n = 1'b0;
    run(15);
    pb_n = 1'b1;
    run(10);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("midreset_level", int'(pb_level), 1);
    check("midreset_valid", int'(press_valid), 0);
    check("midreset_type", int'(press_type), 0);
    run(60);
    check("midreset_type_after", int'(press_type), 0);

    n = cyc;
    push(1, n + 41);
    pb_n = 1'b0;
    run(15);
    pb_n = 1'b1;
    run(60);
    check("post_reset_short_drain", q.size(), 0);
    check("post_reset_short_type", int'(press_type), 1);

    check("final_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
